// File: rtl/vqueue_refill_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vqueue_refill_ctrl_if : burst-read bus between refill controller and memory
// Rev 1.0
// ---------------------------------------------------------------------------
interface vqueue_refill_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_rvalid_i, mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/vqueue_refill_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vqueue_refill_ctrl : keeps a vqueue topped up with fixed-length burst reads
// Rev 1.0
// ---------------------------------------------------------------------------
module vqueue_refill_ctrl #(
  parameter int ADDR_W      = 24,
  parameter int QUEUE_AW    = 5,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 153600
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  input  wire logic                enable_i,
  input  wire logic [ADDR_W-1:0]   base_addr_i,
  input  wire logic                frame_start_i,
  vqueue_refill_ctrl_if.master     mem,
  input  wire logic                q_pop_i,
  output logic                     q_wren_o,
  output logic [31:0]              q_data_o,
  output logic [QUEUE_AW:0]        level_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam int c_LVL_W  = QUEUE_AW + 1;
  localparam int c_OFF_W  = $clog2(FRAME_WORDS + 1);
  localparam int c_BEAT_W = $clog2(BURST_LEN + 1);
  localparam int c_CAP    = (1 << QUEUE_AW) - 1;

  localparam logic [c_LVL_W:0]    c_CAP_X   = (c_LVL_W + 1)'(c_CAP);
  localparam logic [c_LVL_W:0]    c_BURST_X = (c_LVL_W + 1)'(BURST_LEN);
  localparam logic [c_OFF_W-1:0]  c_BURST_O = c_OFF_W'(BURST_LEN);
  localparam logic [c_OFF_W-1:0]  c_FRAME_O = c_OFF_W'(FRAME_WORDS);
  localparam logic [c_BEAT_W-1:0] c_LAST_B  = c_BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_pending;
  logic [ADDR_W-1:0]   r_base;
  logic [c_OFF_W-1:0]  r_offset;
  logic [c_BEAT_W-1:0] r_beats;
  logic [c_LVL_W-1:0]  r_level;
  logic                r_req;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_q_wren;
  logic [31:0]         r_q_data;
  logic                r_frame_done;

  logic [c_LVL_W:0]    w_lvl_eff;
  logic                w_space;
  logic                w_pop_eff;
  logic [ADDR_W-1:0]   w_base_sel;
  logic [c_OFF_W-1:0]  w_off_sel;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic [c_OFF_W-1:0]  w_off_next;
  logic                w_wrap;

  // The write registered last edge lands in the queue on this edge, so count it as occupied.
  assign w_lvl_eff    = {1'b0, r_level} + {{c_LVL_W{1'b0}}, r_q_wren};
  assign w_space      = (w_lvl_eff + c_BURST_X) <= c_CAP_X;
  assign w_pop_eff    = q_pop_i && (r_level != '0);

  // A pending restart is applied in the same IDLE cycle that may issue the request.
  assign w_base_sel   = r_pending ? base_addr_i : r_base;
  assign w_off_sel    = r_pending ? '0 : r_offset;
  assign w_issue_addr = w_base_sel + ADDR_W'(w_off_sel);
  assign w_off_next   = r_offset + c_BURST_O;
  assign w_wrap       = (w_off_next == c_FRAME_O);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else begin
      r_level <= r_level + c_LVL_W'(r_q_wren) - c_LVL_W'(w_pop_eff);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pending    <= 1'b1;
      r_base       <= '0;
      r_offset     <= '0;
      r_beats      <= '0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_q_wren     <= 1'b0;
      r_q_data     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_q_wren     <= 1'b0;
      r_frame_done <= 1'b0;
      if (frame_start_i) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            r_base   <= base_addr_i;
            r_offset <= '0;
            if (!frame_start_i) begin
              r_pending <= 1'b0;
            end
          end
          if (enable_i && w_space) begin
            r_req   <= 1'b1;
            r_addr  <= w_issue_addr;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.mem_ack_i) begin
            r_req        <= 1'b0;
            r_beats      <= '0;
            r_state      <= ST_DATA;
            r_offset     <= w_wrap ? '0 : w_off_next;
            r_frame_done <= w_wrap;
          end
        end
        ST_DATA: begin
          if (mem.mem_rvalid_i) begin
            r_q_wren <= 1'b1;
            r_q_data <= mem.mem_rdata_i;
            r_beats  <= r_beats + c_BEAT_W'(1);
            if (r_beats == c_LAST_B) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req_o  = r_req;
  assign mem.mem_addr_o = r_addr;
  assign q_wren_o       = r_q_wren;
  assign q_data_o       = r_q_data;
  assign level_o        = r_level;
  assign busy_o         = (r_state != ST_IDLE);
  assign frame_done_o   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_vqueue_refill_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vqueue_refill_ctrl : randomized memory/consumer against a transaction model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vqueue_refill_ctrl;
  localparam int ADDR_W = 24;
  localparam int QAW    = 5;
  localparam int BL     = 8;
  localparam int FRAME  = 32;
  localparam int CAP    = (1 << QAW) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              frame_start_i;
  logic              q_pop_i;
  logic              q_wren_o;
  logic [31:0]       q_data_o;
  logic [QAW:0]      level_o;
  logic              busy_o;
  logic              frame_done_o;

  vqueue_refill_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

  vqueue_refill_ctrl #(
    .ADDR_W(ADDR_W), .QUEUE_AW(QAW), .BURST_LEN(BL), .FRAME_WORDS(FRAME)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .base_addr_i(base_addr_i),
    .frame_start_i(frame_start_i), .mem(mem_bus), .q_pop_i(q_pop_i),
    .q_wren_o(q_wren_o), .q_data_o(q_data_o), .level_o(level_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Transaction-level model: occupancy, burst bookkeeping and address walk.
  int              m_lvl, m_beats, m_off, n_req, eff_before;
  logic            m_wren, m_fd, in_burst, m_pending, req_seen;
  logic [31:0]     m_data;
  logic [ADDR_W-1:0] m_base, exp_addr;
  logic            p_ack, p_beat, p_pop;
  logic [31:0]     p_data;
  int              pop_pct   = 0;
  logic            force_pop = 1'b0;

  initial begin
    mem_bus.mem_ack_i    = 1'b0;
    mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_rdata_i  = '0;
    q_pop_i              = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_lvl = 0; m_wren = 0; m_fd = 0; in_burst = 0; m_beats = 0; m_off = 0;
        m_pending = 1; req_seen = 0; n_req = 0; m_data = '0; m_base = '0; exp_addr = '0;
        p_ack = 0; p_beat = 0; p_pop = 0; p_data = '0;
        mem_bus.mem_ack_i = 0; mem_bus.mem_rvalid_i = 0; q_pop_i = 0;
      end else begin
        eff_before = m_lvl + int'(m_wren);
        m_lvl = m_lvl + int'(m_wren) - ((p_pop && m_lvl != 0) ? 1 : 0);
        m_wren = p_beat;
        if (p_beat) m_data = p_data;
        m_fd = 1'b0;
        if (p_ack) begin
          in_burst = 1; m_beats = 0;
          m_fd  = (m_off + BL == FRAME);
          m_off = (m_off + BL) % FRAME;
          chk("req_drop_after_ack", mem_bus.mem_req_o, 0);
        end
        if (p_beat) begin
          m_beats++;
          if (m_beats == BL) in_burst = 0;
        end

        chk("q_wren", q_wren_o, m_wren);
        if (m_wren) chk("q_data", q_data_o, m_data);
        chk("level", level_o, m_lvl);
        chk("level_le_cap", (m_lvl <= CAP && level_o <= CAP), 1);
        chk("frame_done", frame_done_o, m_fd);
        chk("busy", busy_o, mem_bus.mem_req_o || in_burst);

        if (mem_bus.mem_req_o && !req_seen) begin
          if (m_pending) begin
            m_base = base_addr_i; m_off = 0; m_pending = 0;
          end
          exp_addr = m_base + ADDR_W'(m_off);
          chk("req_addr", mem_bus.mem_addr_o, exp_addr);
          chk("req_space", (eff_before + BL <= CAP), 1);
          n_req++;
        end else if (mem_bus.mem_req_o) begin
          chk("req_addr_hold", mem_bus.mem_addr_o, exp_addr);
        end
        req_seen = mem_bus.mem_req_o;
        if (frame_start_i) m_pending = 1;

        p_ack  = mem_bus.mem_req_o && !p_ack && ($urandom_range(3) == 0);
        p_beat = in_burst && ($urandom_range(3) != 0);
        p_data = $urandom;
        p_pop  = force_pop || ($urandom_range(99) < pop_pct);
        mem_bus.mem_ack_i    = p_ack;
        mem_bus.mem_rvalid_i = p_beat || (!in_burst && $urandom_range(3) == 0);
        mem_bus.mem_rdata_i  = p_data;
        q_pop_i              = p_pop;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; enable_i = 0; base_addr_i = 24'h001000; frame_start_i = 0;
    sync(); sync();
    chk("rst_req",   mem_bus.mem_req_o, 0);
    chk("rst_addr",  mem_bus.mem_addr_o, 0);
    chk("rst_wren",  q_wren_o, 0);
    chk("rst_data",  q_data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_fd",    frame_done_o, 0);
    reset_n = 1; enable_i = 1;

    // Fill with no consumer: three bursts, then no room for a fourth.
    for (int i = 0; i < 400 && !(m_lvl == 24 && !in_burst && !mem_bus.mem_req_o); i++) sync();
    chk("fill_level", level_o, 24);
    chk("fill_nreq", n_req, 3);
    repeat (20) sync();
    chk("fill_no_4th_req", mem_bus.mem_req_o, 0);
    chk("fill_idle", busy_o, 0);

    // One pop frees exactly one burst of room.
    force_pop = 1; sync(); force_pop = 0;
    for (int i = 0; i < 4 && !mem_bus.mem_req_o; i++) sync();
    chk("pop_req", mem_bus.mem_req_o, 1);
    chk("pop_req_addr", mem_bus.mem_addr_o, 24'h001018);
    for (int i = 0; i < 300 && !(m_lvl == 31 && !in_burst && !mem_bus.mem_req_o); i++) sync();
    repeat (10) sync();
    chk("full_level", level_o, 31);
    chk("full_no_req", mem_bus.mem_req_o, 0);

    // Random traffic across several frame wraps.
    pop_pct = 50;
    repeat (400) sync();

    // Restart mid-burst with a new base.
    for (int i = 0; i < 300 && !(in_burst && m_beats >= 2); i++) sync();
    chk("restart_in_burst", in_burst, 1);
    base_addr_i = 24'h002000; frame_start_i = 1;
    sync();
    frame_start_i = 0;
    for (int i = 0; i < 300 && !mem_bus.mem_req_o; i++) sync();
    chk("restart_req", mem_bus.mem_req_o, 1);
    chk("restart_addr", mem_bus.mem_addr_o, 24'h002000);

    // Drain, then pop continuously at empty while refilling.
    enable_i = 0; pop_pct = 100;
    for (int i = 0; i < 400 && !(m_lvl == 0 && !m_wren && !in_burst && !mem_bus.mem_req_o); i++) sync();
    chk("drain_level", level_o, 0);
    enable_i = 1;
    for (int i = 0; i < 100 && !(q_wren_o && level_o == 0); i++) sync();
    chk("empty_first_write", q_wren_o && level_o == 0, 1);
    sync();
    chk("empty_write_with_pop", level_o, 1);
    enable_i = 0;
    repeat (40) sync();
    chk("empty_stays_zero", level_o, 0);

    // Asynchronous reset in the middle of a burst.
    enable_i = 1; pop_pct = 50;
    for (int i = 0; i < 300 && !(in_burst && m_beats == 3); i++) sync();
    chk("areset_in_burst", in_burst, 1);
    reset_n = 0;
    #1;
    chk("areset_req",   mem_bus.mem_req_o, 0);
    chk("areset_addr",  mem_bus.mem_addr_o, 0);
    chk("areset_wren",  q_wren_o, 0);
    chk("areset_data",  q_data_o, 0);
    chk("areset_level", level_o, 0);
    chk("areset_busy",  busy_o, 0);
    chk("areset_fd",    frame_done_o, 0);
    base_addr_i = 24'h003000;
    repeat (3) sync();
    reset_n = 1;
    for (int i = 0; i < 5 && !mem_bus.mem_req_o; i++) sync();
    chk("post_reset_req", mem_bus.mem_req_o, 1);
    chk("post_reset_addr", mem_bus.mem_addr_o, 24'h003000);
    repeat (100) sync();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
